// File: rtl/if_stage.sv
// Instruction fetch stage: issues word fetches on a single-outstanding
// req/gnt/rvalid bus, buffers responses with their PC in a small prefetch
// FIFO and handles controller redirects by flushing buffered and in-flight
// fetches.
module if_stage #(
   parameter int unsigned                  RISCV_ADDR_WIDTH = 32,
   parameter logic [RISCV_ADDR_WIDTH-1:0]  BOOT_ADDR        = 32'h0000_0080,
   parameter int unsigned                  FIFO_DEPTH       = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   // instruction memory bus
   output logic                        instr_req_o,
   output logic [RISCV_ADDR_WIDTH-1:0] instr_addr_o,
   input  logic                        instr_gnt_i,
   input  logic                        instr_rvalid_i,
   input  logic [31:0]                 instr_rdata_i,
   // decode side
   output logic                        inst_valid_o,
   output logic [31:0]                 inst_rdata_o,
   output logic [RISCV_ADDR_WIDTH-1:0] pc_o,
   input  logic                        inst_ready_i,
   // controller redirect
   input  logic                        target_valid_i,
   input  logic [1:0]                  pc_mux_sel_i,
   input  logic [RISCV_ADDR_WIDTH-1:0] branch_target_i,
   input  logic [RISCV_ADDR_WIDTH-1:0] exc_pc_i,
   input  logic [RISCV_ADDR_WIDTH-1:0] epc_i
);

   localparam logic [1:0] PC_BRANCH_JUMP = 2'd0;
   localparam logic [1:0] PC_EXCEPTION   = 2'd1;
   localparam logic [1:0] PC_EPC         = 2'd2;

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

   typedef logic [RISCV_ADDR_WIDTH-1:0] addr_t;
   typedef logic [PTR_W-1:0]            ptr_t;
   typedef logic [CNT_W-1:0]            cnt_t;

   typedef enum logic [1:0] {StIdle, StReq, StWait} state_t;

   state_t state_q;
   addr_t  fetch_addr_q, fetch_addr_d;
   addr_t  req_pc_q;
   addr_t  redirect_addr;
   logic   discard_q, discard_d;

   // prefetch FIFO storage, packed so it can be cleared in one assignment
   logic [FIFO_DEPTH-1:0][31:0]             data_q;
   logic [FIFO_DEPTH-1:0][RISCV_ADDR_WIDTH-1:0] pc_q;
   ptr_t   rptr_q, wptr_q;
   cnt_t   count_q, count_d;

   logic   redirect;
   logic   gnt_fire;
   logic   rsp_fire;
   logic   push;
   logic   pop;
   logic   has_room;

   assign redirect = target_valid_i;
   assign gnt_fire = (state_q == StReq) && instr_gnt_i;
   assign rsp_fire = (state_q == StWait) && instr_rvalid_i;

   // A redirect flushes the FIFO, so it overrides any push or pop that cycle.
   assign push = rsp_fire && !discard_q && !redirect;
   assign pop  = inst_valid_o && inst_ready_i && !redirect;

   assign inst_valid_o = (count_q != '0);
   assign inst_rdata_o = data_q[rptr_q];
   assign pc_o         = pc_q[rptr_q];

   // Select the redirect target and force word alignment.
   always_comb begin
      redirect_addr = branch_target_i;
      case (pc_mux_sel_i)
         PC_BRANCH_JUMP: redirect_addr = branch_target_i;
         PC_EXCEPTION:   redirect_addr = exc_pc_i;
         PC_EPC:         redirect_addr = epc_i;
         default:        redirect_addr = branch_target_i;
      endcase
      redirect_addr[1:0] = 2'b00;
   end

   // FIFO occupancy after this cycle's flush, push and pop.
   always_comb begin
      count_d = count_q;
      if (redirect) begin
         count_d = '0;
      end else begin
         count_d = count_q + cnt_t'(push) - cnt_t'(pop);
      end
   end

   // No transaction is outstanding whenever this is consulted, so a free
   // slot exists exactly when the post-update count is below the depth.
   assign has_room = (count_d < cnt_t'(FIFO_DEPTH));

   // Next fetch address; a grant for a request that was already redirected
   // must not advance past the redirect target.
   always_comb begin
      fetch_addr_d = fetch_addr_q;
      if (redirect) begin
         fetch_addr_d = redirect_addr;
      end else if (gnt_fire && !discard_q) begin
         fetch_addr_d = fetch_addr_q + addr_t'(4);
      end
   end

   // Discard marks the single in-flight or pending-grant request as stale.
   always_comb begin
      discard_d = discard_q;
      if (rsp_fire) begin
         discard_d = 1'b0;
      end else if (redirect && (state_q != StIdle)) begin
         discard_d = 1'b1;
      end
   end

   // Fetch address and discard flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_addr_q <= BOOT_ADDR;
         discard_q    <= 1'b0;
      end else begin
         fetch_addr_q <= fetch_addr_d;
         discard_q    <= discard_d;
      end
   end

   // Bus FSM with registered request and address; address holds until grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         instr_req_o  <= 1'b0;
         instr_addr_o <= '0;
         req_pc_q     <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (has_room) begin
                  state_q      <= StReq;
                  instr_req_o  <= 1'b1;
                  instr_addr_o <= fetch_addr_d;
               end
            end
            StReq: begin
               if (instr_gnt_i) begin
                  state_q     <= StWait;
                  instr_req_o <= 1'b0;
                  req_pc_q    <= instr_addr_o;
               end
            end
            StWait: begin
               if (instr_rvalid_i) begin
                  if (has_room) begin
                     state_q      <= StReq;
                     instr_req_o  <= 1'b1;
                     instr_addr_o <= fetch_addr_d;
                  end else begin
                     state_q <= StIdle;
                  end
               end
            end
            default: begin
               state_q     <= StIdle;
               instr_req_o <= 1'b0;
            end
         endcase
      end
   end

   // Prefetch FIFO: pointers, count and storage; a redirect empties it.
   always_ff @(posedge clk) begin
      if (rst) begin
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
         data_q  <= '0;
         pc_q    <= '0;
      end else begin
         if (redirect) begin
            rptr_q <= '0;
            wptr_q <= '0;
         end else begin
            if (push) begin
               data_q[wptr_q] <= instr_rdata_i;
               pc_q[wptr_q]   <= req_pc_q;
               wptr_q         <= wptr_q + ptr_t'(1);
            end
            if (pop) begin
               rptr_q <= rptr_q + ptr_t'(1);
            end
         end
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a behavioural instruction memory that
// returns ~address as data after a programmable latency.
module tb_if_stage;

   localparam logic [1:0] PC_BRANCH_JUMP = 2'd0;
   localparam logic [1:0] PC_EXCEPTION   = 2'd1;
   localparam logic [1:0] PC_EPC         = 2'd2;
   localparam int unsigned FIFO_DEPTH    = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        instr_req_o;
   logic [31:0] instr_addr_o;
   logic        instr_gnt_i = 1'b0;
   logic        instr_rvalid_i = 1'b0;
   logic [31:0] instr_rdata_i = '0;
   logic        inst_valid_o;
   logic [31:0] inst_rdata_o;
   logic [31:0] pc_o;
   logic        inst_ready_i = 1'b0;
   logic        target_valid_i = 1'b0;
   logic [1:0]  pc_mux_sel_i = 2'd0;
   logic [31:0] branch_target_i = '0;
   logic [31:0] exc_pc_i = '0;
   logic [31:0] epc_i = '0;

   if_stage #(
      .RISCV_ADDR_WIDTH (32),
      .BOOT_ADDR        (32'h0000_0080),
      .FIFO_DEPTH       (FIFO_DEPTH)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .instr_req_o     (instr_req_o),
      .instr_addr_o    (instr_addr_o),
      .instr_gnt_i     (instr_gnt_i),
      .instr_rvalid_i  (instr_rvalid_i),
      .instr_rdata_i   (instr_rdata_i),
      .inst_valid_o    (inst_valid_o),
      .inst_rdata_o    (inst_rdata_o),
      .pc_o            (pc_o),
      .inst_ready_i    (inst_ready_i),
      .target_valid_i  (target_valid_i),
      .pc_mux_sel_i    (pc_mux_sel_i),
      .branch_target_i (branch_target_i),
      .exc_pc_i        (exc_pc_i),
      .epc_i           (epc_i)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int gnt_en = 1;
   int rlat = 1;
   int pend_cnt = 0;
   logic [31:0] pend_addr = '0;
   logic [31:0] gnt_q[$];
   logic [31:0] pop_pc[$];
   logic [31:0] pop_data[$];
   int          pop_cyc[$];
   int first_rv = -1;
   int first_v = -1;
   logic        hold_prev = 1'b0;
   logic [31:0] addr_prev = '0;

   // Memory model: grants when enabled, returns ~addr rlat cycles after grant.
   always @(posedge clk) begin
      #3;
      instr_rvalid_i = 1'b0;
      instr_gnt_i = 1'b0;
      if (pend_cnt == 1) begin
         instr_rvalid_i = 1'b1;
         instr_rdata_i = ~pend_addr;
         pend_cnt = 0;
      end else if (pend_cnt > 1) begin
         pend_cnt = pend_cnt - 1;
      end
      if (instr_req_o && gnt_en != 0) begin
         instr_gnt_i = 1'b1;
         pend_cnt = rlat;
         pend_addr = instr_addr_o;
      end
   end

   // Monitor: logs grants and pops, checks bus stability and FIFO overflow.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (!rst) begin
         if (instr_req_o && instr_gnt_i) gnt_q.push_back(instr_addr_o);
         if (inst_valid_o && inst_ready_i && !target_valid_i) begin
            pop_pc.push_back(pc_o);
            pop_data.push_back(inst_rdata_o);
            pop_cyc.push_back(cyc);
         end
         if (instr_rvalid_i && first_rv < 0) first_rv = cyc;
         if (inst_valid_o && first_v < 0) first_v = cyc;
         if (hold_prev && (!instr_req_o || instr_addr_o !== addr_prev)) begin
            errors++;
            $display("FAIL req_stable req=%0b addr=%h expected req=1 addr=%h",
                     instr_req_o, instr_addr_o, addr_prev);
         end
         if (dut.push && !dut.pop && dut.count_q == 2'(FIFO_DEPTH)) begin
            errors++;
            $display("FAIL fifo_overflow push while full, count=%0d", dut.count_q);
         end
      end
      hold_prev = !rst && instr_req_o && !instr_gnt_i;
      addr_prev = instr_addr_o;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic clear_logs();
      gnt_q.delete();
      pop_pc.delete();
      pop_data.delete();
      pop_cyc.delete();
   endtask

   task automatic do_reset(input logic ready_v);
      rst = 1'b1;
      inst_ready_i = ready_v;
      target_valid_i = 1'b0;
      gnt_en = 1;
      rlat = 1;
      pend_cnt = 0;
      step(2);
      clear_logs();
      first_rv = -1;
      first_v = -1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(3);
      @(negedge clk);
      checks++; if (instr_req_o !== 1'b0) begin errors++;
         $display("FAIL reset_req got %b exp 0", instr_req_o); end
      checks++; if (inst_valid_o !== 1'b0) begin errors++;
         $display("FAIL reset_valid got %b exp 0", inst_valid_o); end
      checks++; if (inst_rdata_o !== 32'h0) begin errors++;
         $display("FAIL reset_rdata got %h exp 0", inst_rdata_o); end
      checks++; if (pc_o !== 32'h0) begin errors++;
         $display("FAIL reset_pc got %h exp 0", pc_o); end
   endtask

   task automatic test_stream();
      logic [31:0] exp_pc;
      do_reset(1'b1);
      for (int i = 0; i < 40 && pop_pc.size() < 3; i++) step(1);
      checks++; if (pop_pc.size() < 3) begin errors++;
         $display("FAIL stream_pops got %0d exp 3", pop_pc.size()); end
      checks++; if (gnt_q.size() < 1 || gnt_q[0] !== 32'h80) begin errors++;
         $display("FAIL stream_first_addr got %h exp 00000080",
                  gnt_q.size() > 0 ? gnt_q[0] : 32'hx); end
      for (int k = 0; k < 3 && k < pop_pc.size(); k++) begin
         exp_pc = 32'h80 + 32'(4 * k);
         checks++; if (pop_pc[k] !== exp_pc) begin errors++;
            $display("FAIL stream_pc%0d got %h exp %h", k, pop_pc[k], exp_pc); end
         checks++; if (pop_data[k] !== ~exp_pc) begin errors++;
            $display("FAIL stream_data%0d got %h exp %h", k, pop_data[k], ~exp_pc); end
      end
      checks++; if (first_v - first_rv != 1) begin errors++;
         $display("FAIL stream_latency got %0d exp 1", first_v - first_rv); end
   endtask

   task automatic test_backpressure();
      do_reset(1'b0);
      step(12);
      @(negedge clk);
      checks++; if (instr_req_o !== 1'b0) begin errors++;
         $display("FAIL bp_req_idle got %b exp 0", instr_req_o); end
      checks++; if (gnt_q.size() != 2) begin errors++;
         $display("FAIL bp_grants got %0d exp 2", gnt_q.size()); end
      checks++; if (gnt_q.size() < 2 || gnt_q[1] !== 32'h84) begin errors++;
         $display("FAIL bp_second_addr got %h exp 00000084",
                  gnt_q.size() > 1 ? gnt_q[1] : 32'hx); end
      checks++; if (inst_valid_o !== 1'b1 || pc_o !== 32'h80) begin errors++;
         $display("FAIL bp_head got valid=%b pc=%h exp valid=1 pc=00000080",
                  inst_valid_o, pc_o); end
      checks++; if (inst_rdata_o !== ~32'h80) begin errors++;
         $display("FAIL bp_head_data got %h exp %h", inst_rdata_o, ~32'h80); end
      step(1);
      inst_ready_i = 1'b1;
      step(1);
      inst_ready_i = 1'b0;
      step(8);
      @(negedge clk);
      checks++; if (gnt_q.size() != 3) begin errors++;
         $display("FAIL bp_refill_grants got %0d exp 3", gnt_q.size()); end
      checks++; if (gnt_q.size() < 3 || gnt_q[2] !== 32'h88) begin errors++;
         $display("FAIL bp_refill_addr got %h exp 00000088",
                  gnt_q.size() > 2 ? gnt_q[2] : 32'hx); end
      checks++; if (instr_req_o !== 1'b0 || pc_o !== 32'h84) begin errors++;
         $display("FAIL bp_after_pop got req=%b pc=%h exp req=0 pc=00000084",
                  instr_req_o, pc_o); end
      checks++; if (pop_pc.size() != 1 || pop_pc[0] !== 32'h80) begin errors++;
         $display("FAIL bp_popped got n=%0d exp 1 pop of 00000080", pop_pc.size()); end
      step(1);
   endtask

   task automatic test_redirect_branch();
      int red_cyc;
      do_reset(1'b0);
      step(12);
      inst_ready_i = 1'b1;
      step(1);
      inst_ready_i = 1'b0;
      step(6);
      rlat = 4;
      inst_ready_i = 1'b1;
      step(1);
      inst_ready_i = 1'b0;
      for (int i = 0; i < 10 && gnt_q.size() < 4; i++) step(1);
      checks++; if (gnt_q.size() != 4 || gnt_q[3] !== 32'h8C) begin errors++;
         $display("FAIL br_setup got n=%0d exp 4 grants ending 0000008c", gnt_q.size()); end
      // DUT now waits for the 0x8C response with 0x88 buffered
      target_valid_i = 1'b1;
      pc_mux_sel_i = PC_BRANCH_JUMP;
      branch_target_i = 32'h200;
      red_cyc = cyc + 1;
      step(1);
      target_valid_i = 1'b0;
      inst_ready_i = 1'b1;
      clear_logs();
      @(negedge clk);
      checks++; if (inst_valid_o !== 1'b0) begin errors++;
         $display("FAIL br_flush got valid=%b exp 0", inst_valid_o); end
      for (int i = 0; i < 30 && pop_pc.size() < 2; i++) step(1);
      checks++; if (pop_pc.size() < 2) begin errors++;
         $display("FAIL br_pops got %0d exp 2", pop_pc.size()); end
      else begin
         checks++; if (pop_pc[0] !== 32'h200 || pop_data[0] !== ~32'h200) begin errors++;
            $display("FAIL br_first got pc=%h data=%h exp pc=00000200 data=%h",
                     pop_pc[0], pop_data[0], ~32'h200); end
         checks++; if (pop_pc[1] !== 32'h204) begin errors++;
            $display("FAIL br_second got %h exp 00000204", pop_pc[1]); end
         checks++; if (pop_cyc[0] - red_cyc < 3) begin errors++;
            $display("FAIL br_latency got %0d exp >=3", pop_cyc[0] - red_cyc); end
      end
      checks++; if (gnt_q.size() < 1 || gnt_q[0] !== 32'h200) begin errors++;
         $display("FAIL br_next_addr got %h exp 00000200",
                  gnt_q.size() > 0 ? gnt_q[0] : 32'hx); end
   endtask

   task automatic test_redirect_exc();
      do_reset(1'b1);
      gnt_en = 0;
      step(1);
      target_valid_i = 1'b1;
      pc_mux_sel_i = PC_EXCEPTION;
      exc_pc_i = 32'h10C;
      step(1);
      target_valid_i = 1'b0;
      clear_logs();
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h80) begin errors++;
            $display("FAIL exc_hold%0d got req=%b addr=%h exp req=1 addr=00000080",
                     c, instr_req_o, instr_addr_o); end
         step(1);
      end
      gnt_en = 1;
      for (int i = 0; i < 20 && pop_pc.size() < 1; i++) step(1);
      checks++; if (gnt_q.size() < 2 || gnt_q[0] !== 32'h80 || gnt_q[1] !== 32'h10C)
         begin errors++;
         $display("FAIL exc_grants got n=%0d exp 00000080 then 0000010c", gnt_q.size()); end
      checks++; if (pop_pc.size() < 1 || pop_pc[0] !== 32'h10C || pop_data[0] !== ~32'h10C)
         begin errors++;
         $display("FAIL exc_first got pc=%h exp 0000010c",
                  pop_pc.size() > 0 ? pop_pc[0] : 32'hx); end
   endtask

   task automatic test_epc_wrap();
      do_reset(1'b1);
      step(5);
      target_valid_i = 1'b1;
      pc_mux_sel_i = PC_EPC;
      epc_i = 32'h3E6;
      step(1);
      target_valid_i = 1'b0;
      clear_logs();
      for (int i = 0; i < 20 && pop_pc.size() < 2; i++) step(1);
      checks++; if (gnt_q.size() < 1 || gnt_q[0] !== 32'h3E4) begin errors++;
         $display("FAIL epc_addr got %h exp 000003e4",
                  gnt_q.size() > 0 ? gnt_q[0] : 32'hx); end
      checks++; if (pop_pc.size() < 2 || pop_pc[0] !== 32'h3E4 || pop_data[0] !== ~32'h3E4
                    || pop_pc[1] !== 32'h3E8) begin errors++;
         $display("FAIL epc_pops got n=%0d first=%h exp 000003e4 then 000003e8",
                  pop_pc.size(), pop_pc.size() > 0 ? pop_pc[0] : 32'hx); end
      target_valid_i = 1'b1;
      pc_mux_sel_i = PC_BRANCH_JUMP;
      branch_target_i = 32'hFFFF_FFFF;
      step(1);
      target_valid_i = 1'b0;
      clear_logs();
      for (int i = 0; i < 20 && pop_pc.size() < 2; i++) step(1);
      checks++; if (gnt_q.size() < 2 || gnt_q[0] !== 32'hFFFF_FFFC || gnt_q[1] !== 32'h0)
         begin errors++;
         $display("FAIL wrap_grants got n=%0d exp fffffffc then 00000000", gnt_q.size()); end
      checks++; if (pop_pc.size() < 2 || pop_pc[0] !== 32'hFFFF_FFFC
                    || pop_data[0] !== 32'h0000_0003 || pop_pc[1] !== 32'h0) begin errors++;
         $display("FAIL wrap_pops got n=%0d first=%h exp fffffffc then 00000000",
                  pop_pc.size(), pop_pc.size() > 0 ? pop_pc[0] : 32'hx); end
   endtask

   task automatic test_reset_mid();
      do_reset(1'b0);
      rlat = 3;
      for (int i = 0; i < 10 && gnt_q.size() < 1; i++) step(1);
      checks++; if (gnt_q.size() != 1) begin errors++;
         $display("FAIL rstmid_setup got %0d grants exp 1", gnt_q.size()); end
      step(1);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (inst_valid_o !== 1'b0 || instr_req_o !== 1'b0) begin errors++;
         $display("FAIL rstmid_after got valid=%b req=%b exp 0 0", inst_valid_o, instr_req_o); end
      step(1);
      @(negedge clk);
      checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h80 || inst_valid_o !== 1'b0)
         begin errors++;
         $display("FAIL rstmid_refetch got req=%b addr=%h valid=%b exp 1 00000080 0",
                  instr_req_o, instr_addr_o, inst_valid_o); end
      step(1);
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_branch();
      test_redirect_exc();
      test_epc_wrap();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

endmodule
